mem_port_arbiter: RTL

Shares one single-ported, variable-latency memory between the pipelined CPU's instruction-fetch side (read-only) and its data-access side (read/write). Sits between the CPU and the unified memory. It sequences each access through a small FSM and serialises conflicting requests. Data requests get priority, and a bounded-streak guard prevents fetch starvation. It also supports cancelling a fetch that a branch redirect has made stale.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_WORD_SIZE   = 16;  // default address/data width
    localparam int c_GRANT_CNT_W = 16;  // width of the per-side grant counters
    localparam int c_STREAK_W    = 4;   // holds MAX_D_STREAK up to 15

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        BUSY_X = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Winner selection between fetch and data requesters, with a
//               bounded D-streak counter that keeps fetches from starving.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,     // high only in cycles where an arbitration happens
    input  logic i_req,
    input  logic i_cancel,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(MAX_D_STREAK);

    logic [c_STREAK_W-1:0] r_streak;
    logic                  w_streak_full;

    assign w_streak_full = (r_streak == c_MAX_STREAK);

    // Data wins unless a waiting fetch has already seen a full streak of D grants.
    always_comb begin
        grant_d = arb_en && d_req && !(i_req && w_streak_full);
        grant_i = arb_en && !grant_d && i_req && !i_cancel;
    end

    // Streak only counts D grants that a pending fetch had to sit through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (arb_en) begin
            if (!i_req || grant_i) begin
                r_streak <= '0;
            end else if (grant_d && !w_streak_full) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported, variable-latency memory between a
//               read-only fetch port and a read/write data port. Data has
//               priority; fetches can be cancelled while pending or in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE    = c_WORD_SIZE,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    // fetch side
    input  logic                     i_req,
    input  logic [WORD_SIZE-1:0]     i_addr,
    input  logic                     i_cancel,
    output logic                     i_ack,
    output logic [WORD_SIZE-1:0]     i_rdata,
    // data side
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [WORD_SIZE-1:0]     d_addr,
    input  logic [WORD_SIZE-1:0]     d_wdata,
    output logic                     d_ack,
    output logic [WORD_SIZE-1:0]     d_rdata,
    // memory backend
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WORD_SIZE-1:0]     mem_addr,
    output logic [WORD_SIZE-1:0]     mem_wdata,
    input  logic [WORD_SIZE-1:0]     mem_rdata,
    input  logic                     mem_ack,
    // statistics
    output logic [c_GRANT_CNT_W-1:0] i_grants,
    output logic [c_GRANT_CNT_W-1:0] d_grants
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic w_arb_en;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy_ack;

    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [WORD_SIZE-1:0]     r_mem_addr;
    logic [WORD_SIZE-1:0]     r_mem_wdata;
    logic                     r_i_ack;
    logic                     r_d_ack;
    logic [WORD_SIZE-1:0]     r_i_rdata;
    logic [WORD_SIZE-1:0]     r_d_rdata;
    logic [c_GRANT_CNT_W-1:0] r_i_grants;
    logic [c_GRANT_CNT_W-1:0] r_d_grants;

    assign w_arb_en   = (r_state == IDLE);
    // A backend ack is only meaningful while an access is outstanding.
    assign w_busy_ack = (r_state != IDLE) && mem_ack;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (w_arb_en),
        .i_req    (i_req),
        .i_cancel (i_cancel),
        .d_req    (d_req),
        .grant_i  (w_grant_i),
        .grant_d  (w_grant_d)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a cancel racing the ack still ends the fetch silently.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    w_state_next = IDLE;
                end else if (i_cancel) begin
                    w_state_next = BUSY_X;
                end
            end
            BUSY_D, BUSY_X: begin
                if (mem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Backend command, response capture, ack pulses and grant counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_grants  <= '0;
            r_d_grants  <= '0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_d_grants  <= r_d_grants + 1'b1;
            end else if (w_grant_i) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= i_addr;
                r_i_grants <= r_i_grants + 1'b1;
            end
            if (w_busy_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_state == BUSY_I && !i_cancel) begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= mem_rdata;
                end
                if (r_state == BUSY_D) begin
                    r_d_ack <= 1'b1;
                    if (!r_mem_we) begin
                        r_d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_grants  = r_i_grants;
    assign d_grants  = r_d_grants;

endmodule
`default_nettype wire
